i2c_target: RTL



---
 rtl/i2c_target_if.sv | 26 ++
 rtl/i2c_target.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_if.sv
// Register-side interface of the I2C target: byte hand-off and bus event flags.
interface i2c_target_if;
    logic       ack_en;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       start;
    logic       stop;
    logic       addr_hit;
    logic       rw;
    logic       nack;
    logic       busy;

    // Target side: consumes ack policy and read data, reports events.
    modport slave (
        input  ack_en, tx_data,
        output tx_req, rx_data, rx_valid, start, stop, addr_hit, rw, nack, busy
    );

    // Register/user side.
    modport master (
        output ack_en, tx_data,
        input  tx_req, rx_data, rx_valid, start, stop, addr_hit, rw, nack, busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, single 7-bit address, open-drain SDA.
module i2c_target #(
    parameter logic [6:0]  ADDR        = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         scl_i,
    inout  wire          sda_io,
    i2c_target_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_d_q, sda_d_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]             byte_in;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_drive_q, sda_drive_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       ack_en_q, ack_en_d;
    logic       busy_q, busy_d;
    logic       start_q, start_d, stop_q, stop_d, addr_hit_q, addr_hit_d;
    logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, nack_q, nack_d;

    // Open-drain SDA: only ever pull low; reset releases it asynchronously.
    assign sda_io = sda_drive_q ? 1'b0 : 1'bz;

    // Synchronize SCL/SDA and keep a one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_io};
            scl_d_q    <= scl_sync_q[SYNC_STAGES-1];
            sda_d_q    <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_q;
    assign scl_fall  = ~scl_s & scl_d_q;
    assign start_det = scl_s & scl_d_q & sda_d_q & ~sda_s;
    assign stop_det  = scl_s & scl_d_q & ~sda_d_q & sda_s;
    assign byte_in   = {shift_q[6:0], sda_s};

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'd0;
            sda_drive_q <= 1'b0;
            rw_q        <= 1'b0;
            rx_data_q   <= 8'd0;
            ack_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            addr_hit_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            sda_drive_q <= sda_drive_d;
            rw_q        <= rw_d;
            rx_data_q   <= rx_data_d;
            ack_en_q    <= ack_en_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            addr_hit_q  <= addr_hit_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            nack_q      <= nack_d;
        end
    end

    // Next-state logic; START/STOP override whatever byte is in flight.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        sda_drive_d = sda_drive_q;
        rw_d        = rw_q;
        rx_data_d   = rx_data_q;
        ack_en_d    = ack_en_q;
        busy_d      = busy_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        addr_hit_d  = 1'b0;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        nack_d      = 1'b0;

        if (start_det) begin
            state_d     = S_ADDR;
            cnt_d       = 4'd0;
            sda_drive_d = 1'b0;
            start_d     = 1'b1;
            busy_d      = 1'b1;
        end else if (stop_det) begin
            state_d     = S_IDLE;
            cnt_d       = 4'd0;
            sda_drive_d = 1'b0;
            stop_d      = 1'b1;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (byte_in[7:1] == ADDR) begin
                            rw_d       = byte_in[0];
                            addr_hit_d = 1'b1;
                            state_d    = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                // cnt 0: ACK not yet driven; cnt 1: ACK on the bus.
                S_ADDR_ACK: if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        sda_drive_d = 1'b1;
                        cnt_d       = 4'd1;
                    end else begin
                        sda_drive_d = 1'b0;
                        cnt_d       = 4'd0;
                        if (rw_q) begin
                            tx_req_d = 1'b1;
                            state_d  = S_RD_DATA;
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    shift_d = byte_in;
                    if (cnt_q == 4'd7) begin
                        cnt_d      = 4'd0;
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        ack_en_d   = bus.ack_en;
                        state_d    = S_WR_ACK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_WR_ACK: if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        sda_drive_d = ack_en_q;
                        cnt_d       = 4'd1;
                    end else begin
                        sda_drive_d = 1'b0;
                        cnt_d       = 4'd0;
                        state_d     = S_WR_DATA;
                    end
                end
                // Shift register holds the bits still to be driven after the current one.
                S_RD_DATA: begin
                    if (tx_req_q) begin
                        sda_drive_d = ~bus.tx_data[7];
                        shift_d     = {bus.tx_data[6:0], 1'b0};
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_drive_d = 1'b0;
                            cnt_d       = 4'd0;
                            state_d     = S_RD_ACK;
                        end else begin
                            sda_drive_d = ~shift_q[7];
                            shift_d     = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                // cnt 1 records that the master ACKed and another byte follows.
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            nack_d  = 1'b1;
                            state_d = S_IGNORE;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        tx_req_d = 1'b1;
                        cnt_d    = 4'd0;
                        state_d  = S_RD_DATA;
                    end
                end
                S_IDLE, S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.tx_req   = tx_req_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.start    = start_q;
    assign bus.stop     = stop_q;
    assign bus.addr_hit = addr_hit_q;
    assign bus.rw       = rw_q;
    assign bus.nack     = nack_q;
    assign bus.busy     = busy_q;

endmodule
